// File: rtl/lector_fila_imagen.sv
// lector_fila_imagen: fetches tile row words from the image ROM and serializes them into a 1-bpp pixel stream
module lector_fila_imagen #(
  parameter int         TILE_W    = 32,
  parameter int         ROM_LAT   = 1,
  parameter logic [8:0] BLANK_DIR = 9'h000
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              line_start,
  input  logic              pix_tick,
  input  logic [8:0]        dir_in,
  input  logic              dir_stb,
  output logic              dir_rdy,
  output logic              rom_en,
  output logic [8:0]        rom_addr,
  input  logic [TILE_W-1:0] rom_data,
  output logic              pix_on,
  output logic              underrun,
  output logic              busy
);
  localparam int CW = $clog2(TILE_W);
  localparam int WW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAP} state_t;
  state_t            state, state_n;
  logic [WW-1:0]     wcnt;
  logic              blank, full;
  logic [TILE_W-1:0] hold, sr, cap_word;
  logic [CW-1:0]     px_cnt;
  logic              accept, cap, tile_load, load;
  assign dir_rdy   = state == IDLE && !full;
  assign busy      = state != IDLE;
  assign rom_en    = state == REQ;
  assign accept    = dir_stb && dir_rdy;
  assign cap       = state == CAP;
  assign cap_word  = blank ? '0 : rom_data;
  assign tile_load = pix_tick && px_cnt == CW'(TILE_W - 1) && !line_start;
  assign load      = line_start || tile_load;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? (dir_in == BLANK_DIR ? CAP : REQ) : IDLE;
      REQ:  state_n = WAIT;
      WAIT: state_n = wcnt == WW'(ROM_LAT - 1) ? CAP : WAIT;
      CAP:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state    <= IDLE;
      wcnt     <= '0;
      blank    <= 1'b0;
      rom_addr <= '0;
      full     <= 1'b0;
      hold     <= '0;
      sr       <= '0;
      px_cnt   <= '0;
      pix_on   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= state == WAIT ? wcnt + 1'b1 : '0;
      if (accept) begin
        rom_addr <= dir_in;
        blank    <= dir_in == BLANK_DIR;
      end
      if (line_start) begin
        px_cnt <= '0;
        pix_on <= 1'b0;
      end else if (pix_tick) begin
        px_cnt <= px_cnt == CW'(TILE_W - 1) ? '0 : px_cnt + 1'b1;
        pix_on <= sr[TILE_W-1];
      end
      // a capture landing on a load bypasses the holding register
      if (load) begin
        sr   <= full ? hold : (cap ? cap_word : '0);
        full <= 1'b0;
        if (tile_load && !full && !cap) underrun <= 1'b1;
      end else begin
        if (pix_tick) sr <= sr << 1;
        if (cap) begin
          hold <= cap_word;
          full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lector_fila_imagen.sv
// tb_lector_fila_imagen: directed vector table plus hand-written corner sequences
module tb_lector_fila_imagen;
  logic        reloj = 1'b0, resetM = 1'b1, line_start = 1'b0, pix_tick = 1'b0, dir_stb = 1'b0;
  logic [8:0]  dir_in = 9'h000;
  logic [31:0] rom_data = 32'h0, rom_word = 32'h0;
  logic        dir_rdy, rom_en, pix_on, underrun, busy;
  logic [8:0]  rom_addr;
  int          n_pass = 0, n_tot = 0;

  lector_fila_imagen dut (
    .reloj(reloj), .resetM(resetM), .line_start(line_start), .pix_tick(pix_tick),
    .dir_in(dir_in), .dir_stb(dir_stb), .dir_rdy(dir_rdy), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_on(pix_on), .underrun(underrun), .busy(busy)
  );

  always #5 reloj = ~reloj;
  always @(posedge reloj) if (rom_en) rom_data <= rom_word;

  typedef struct {
    logic       ls, tk, stb;
    logic [8:0] din;
    logic       en, rdy, bsy, pix, und;
  } vec_t;
  vec_t tbl[37];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic ls, input logic tk, input logic stb, input logic [8:0] d);
    line_start = ls; pix_tick = tk; dir_stb = stb; dir_in = d;
    @(posedge reloj); #1;
    line_start = 1'b0; pix_tick = 1'b0; dir_stb = 1'b0;
  endtask

  task automatic idle(); step(1'b0, 1'b0, 1'b0, 9'h000); endtask
  task automatic tick(); step(1'b0, 1'b1, 1'b0, 9'h000); endtask

  task automatic do_reset();
    resetM = 1'b1;
    idle();
    idle();
    resetM = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 9'h065, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 32; i++)
      tbl[5+i] = '{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, (i == 0 || i == 31), (i == 31)};

    do_reset();
    chk("reset dir_rdy", dir_rdy, 1);
    chk("reset rom_en", rom_en, 0);
    chk("reset busy", busy, 0);
    chk("reset pix_on", pix_on, 0);
    chk("reset underrun", underrun, 0);
    chk("reset rom_addr", rom_addr, 0);

    // single fetch of 8000_0001 then one full tile
    rom_word = 32'h8000_0001;
    for (int i = 0; i < 37; i++) begin
      step(tbl[i].ls, tbl[i].tk, tbl[i].stb, tbl[i].din);
      chk($sformatf("vec%0d rom_en", i), rom_en, tbl[i].en);
      chk($sformatf("vec%0d dir_rdy", i), dir_rdy, tbl[i].rdy);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d pix_on", i), pix_on, tbl[i].pix);
      chk($sformatf("vec%0d underrun", i), underrun, tbl[i].und);
      if (i == 0) chk("vec0 rom_addr", rom_addr, 9'h065);
    end

    // reset asserted while the fetch is in WAIT
    do_reset();
    rom_word = 32'h1234_5678;
    step(1'b0, 1'b0, 1'b1, 9'h065);
    idle();
    chk("midrst in wait", busy, 1);
    resetM = 1'b1;
    idle();
    resetM = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst rom_addr", rom_addr, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("midrst rom_en%0d", i), rom_en, 0);
      chk($sformatf("midrst dir_rdy%0d", i), dir_rdy, 1);
    end
    step(1'b1, 1'b0, 1'b0, 9'h000);
    tick();
    chk("midrst pix", pix_on, 0);

    // blank address: all-ones tile followed by an all-zero tile
    do_reset();
    rom_word = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b1, 9'h065);
    idle(); idle(); idle();
    step(1'b1, 1'b0, 1'b0, 9'h000);
    step(1'b0, 1'b0, 1'b1, 9'h000);
    chk("blank rom_en a", rom_en, 0);
    chk("blank busy", busy, 1);
    idle();
    chk("blank rom_en b", rom_en, 0);
    chk("blank full", dir_rdy, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("blank ones%0d", i), pix_on, 1);
    end
    chk("blank underrun", underrun, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("blank zeros%0d", i), pix_on, 0);
    end

    // underrun is sticky across a later good tile
    do_reset();
    step(1'b1, 1'b0, 1'b0, 9'h000);
    repeat (31) tick();
    chk("und before", underrun, 0);
    tick();
    chk("und set", underrun, 1);
    rom_word = 32'h8000_0000;
    step(1'b0, 1'b0, 1'b1, 9'h065);
    idle(); idle(); idle();
    chk("und holding full", dir_rdy, 0);
    repeat (32) tick();
    chk("und after load", underrun, 1);
    chk("und holding used", dir_rdy, 1);
    tick();
    chk("und good pix", pix_on, 1);
    chk("und sticky", underrun, 1);

    // capture coincides with the tile-load tick
    do_reset();
    rom_word = 32'hF000_0000;
    step(1'b1, 1'b0, 1'b0, 9'h000);
    repeat (31) tick();
    step(1'b0, 1'b0, 1'b1, 9'h065);
    idle();
    idle();
    chk("byp in cap", busy, 1);
    tick();
    chk("byp underrun", underrun, 0);
    chk("byp dir_rdy", dir_rdy, 1);
    chk("byp busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("byp pix%0d", i), pix_on, i < 4);
    end
    chk("byp underrun end", underrun, 0);

    // strobes while busy or holding full are ignored
    do_reset();
    rom_word = 32'h0000_0001;
    step(1'b0, 1'b0, 1'b1, 9'h065);
    step(1'b0, 1'b0, 1'b1, 9'h0A3);
    chk("ign rom_en a", rom_en, 0);
    chk("ign addr a", rom_addr, 9'h065);
    step(1'b0, 1'b0, 1'b1, 9'h0A3);
    step(1'b0, 1'b0, 1'b1, 9'h0A3);
    chk("ign full", dir_rdy, 0);
    step(1'b0, 1'b0, 1'b1, 9'h0A3);
    step(1'b0, 1'b0, 1'b1, 9'h0A3);
    chk("ign rom_en b", rom_en, 0);
    chk("ign busy", busy, 0);
    chk("ign addr b", rom_addr, 9'h065);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
